// File: rtl/muldiv_seq_pkg.sv
// rtl/muldiv_seq_pkg.sv - command, flag and state encodings shared by the muldiv sequencer and its bench
package muldiv_seq_pkg;

   localparam logic [5:0] CMD_MUL  = 6'h18;
   localparam logic [5:0] CMD_IMUL = 6'h19;
   localparam logic [5:0] CMD_DIV  = 6'h1A;
   localparam logic [5:0] CMD_IDIV = 6'h1B;

   // Bit positions inside the 5-bit {CF,PF,ZF,SF,OF} status word
   localparam int EFLAGS_CF = 4;
   localparam int EFLAGS_PF = 3;
   localparam int EFLAGS_ZF = 2;
   localparam int EFLAGS_SF = 1;
   localparam int EFLAGS_OF = 0;

   localparam logic [1:0] MULDIV_ST_IDLE = 2'd0;
   localparam logic [1:0] MULDIV_ST_RUN  = 2'd1;
   localparam logic [1:0] MULDIV_ST_FIX  = 2'd2;
   localparam logic [1:0] MULDIV_ST_DONE = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = MULDIV_ST_IDLE,
      ST_RUN  = MULDIV_ST_RUN,
      ST_FIX  = MULDIV_ST_FIX,
      ST_DONE = MULDIV_ST_DONE
   } muldiv_state_e;

   function automatic logic [4:0] mul_status(input logic [4:0] st, input logic ovf);
      logic [4:0] r;
      r            = st;
      r[EFLAGS_CF] = ovf;
      r[EFLAGS_OF] = ovf;
      return r;
   endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// rtl/muldiv_seq_if.sv - request/response bundle between execute (master) and the muldiv sequencer (slave)
interface muldiv_seq_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [5:0]       opc;
   logic [WIDTH-1:0] opnd0_r;
   logic [WIDTH-1:0] opnd1_r;
   logic [WIDTH-1:0] divd_hi_r;
   logic [4:0]       status_in;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result_lo;
   logic [WIDTH-1:0] result_hi;
   logic [4:0]       status_out;
   logic             div_fault;

   modport master (
      output in_valid, opc, opnd0_r, opnd1_r, divd_hi_r, status_in, flush, out_ready,
      input  in_ready, out_valid, result_lo, result_hi, status_out, div_fault
   );

   modport slave (
      input  in_valid, opc, opnd0_r, opnd1_r, divd_hi_r, status_in, flush, out_ready,
      output in_ready, out_valid, result_lo, result_hi, status_out, div_fault
   );
endinterface

// File: rtl/muldiv_seq_step.sv
// rtl/muldiv_seq_step.sv - one combinational shift-add (mul) or restoring shift-subtract (div) step on {acc,q}
module muldiv_step #(
   parameter int WIDTH = 32
) (
   input  logic             is_div_i,
   input  logic [WIDTH-1:0] acc_i,
   input  logic [WIDTH-1:0] q_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] acc_o,
   output logic [WIDTH-1:0] q_o
);
   logic [WIDTH:0] sum;
   logic [WIDTH:0] rem;
   logic [WIDTH:0] diff;

   always_comb begin
      sum  = {1'b0, acc_i} + (q_i[0] ? {1'b0, b_i} : '0);
      rem  = {acc_i, q_i[WIDTH-1]};
      // acc < divisor holds on entry, so diff[WIDTH] is a clean borrow
      diff = rem - {1'b0, b_i};
      if (is_div_i) begin
         if (!diff[WIDTH]) begin
            acc_o = diff[WIDTH-1:0];
            q_o   = {q_i[WIDTH-2:0], 1'b1};
         end else begin
            acc_o = rem[WIDTH-1:0];
            q_o   = {q_i[WIDTH-2:0], 1'b0};
         end
      end else begin
         acc_o = sum[WIDTH:1];
         q_o   = {sum[0], q_i[WIDTH-1:1]};
      end
   end
endmodule

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - multi-cycle MUL/IMUL/DIV/IDIV sequencer with signed fix-up and divide-fault detection
// Optional MULDIV_EARLY_OUT_EN: multiplies finish early once the remaining multiplier bits are zero.
module muldiv_seq
   import muldiv_seq_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input logic         clk,
   input logic         rst_n,
   muldiv_seq_if.slave bus
);
   localparam int            CW       = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);

   muldiv_state_e    state_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] acc_q, q_q, b_q;
   logic [5:0]       op_q;
   logic             neg_res_q, neg_rem_q, ovf_q;
   logic [4:0]       st_in_q;
   logic             out_valid_q, fault_q;
   logic [WIDTH-1:0] res_lo_q, res_hi_q;
   logic [4:0]       st_out_q;

   logic             is_mul_in, is_imul_in, is_div_in, is_idiv_in;
   logic             sgn0, sgn1;
   logic [WIDTH-1:0] mag0, mag1;
   logic [2*WIDTH-1:0] dvd_mag;
   logic             early_fault;

   logic             is_div_q;
   logic [WIDTH-1:0] acc_d, q_d;
   logic [2*WIDTH-1:0] prod_fx;
   logic [WIDTH-1:0] quo_fx, rem_fx;
   logic             quo_ovf, mul_ovf;

   assign bus.in_ready   = (state_q == ST_IDLE);
   assign bus.out_valid  = out_valid_q;
   assign bus.result_lo  = res_lo_q;
   assign bus.result_hi  = res_hi_q;
   assign bus.status_out = st_out_q;
   assign bus.div_fault  = fault_q;

   // Signed commands are converted to magnitudes on capture; sgn0 is the multiplicand/dividend sign
   always_comb begin
      is_mul_in   = (bus.opc == CMD_MUL);
      is_imul_in  = (bus.opc == CMD_IMUL);
      is_div_in   = (bus.opc == CMD_DIV);
      is_idiv_in  = (bus.opc == CMD_IDIV);
      sgn0        = is_imul_in ? bus.opnd0_r[WIDTH-1] : (is_idiv_in & bus.divd_hi_r[WIDTH-1]);
      sgn1        = (is_imul_in | is_idiv_in) & bus.opnd1_r[WIDTH-1];
      mag0        = (is_imul_in & sgn0) ? -bus.opnd0_r : bus.opnd0_r;
      mag1        = sgn1 ? -bus.opnd1_r : bus.opnd1_r;
      dvd_mag     = (is_idiv_in & sgn0) ? -{bus.divd_hi_r, bus.opnd0_r} : {bus.divd_hi_r, bus.opnd0_r};
      early_fault = ((is_div_in | is_idiv_in) & (bus.opnd1_r == '0))
                  | (is_div_in & (bus.divd_hi_r >= bus.opnd1_r));
   end

   assign is_div_q = (op_q == CMD_DIV) | (op_q == CMD_IDIV);

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .is_div_i (is_div_q),
      .acc_i    (acc_q),
      .q_i      (q_q),
      .b_i      (b_q),
      .acc_o    (acc_d),
      .q_o      (q_d)
   );

   always_comb begin
      prod_fx = neg_res_q ? -{acc_q, q_q} : {acc_q, q_q};
      mul_ovf = (op_q == CMD_IMUL) ? (prod_fx[2*WIDTH-1:WIDTH] != {WIDTH{prod_fx[WIDTH-1]}})
                                   : (prod_fx[2*WIDTH-1:WIDTH] != '0);
      quo_fx  = neg_res_q ? -q_q : q_q;
      rem_fx  = neg_rem_q ? -acc_q : acc_q;
      // A negative quotient may reach -2^(W-1); a positive one must stay below 2^(W-1)
      quo_ovf = ovf_q | (q_q[WIDTH-1] & (~neg_res_q | (|q_q[WIDTH-2:0])));
   end

`ifdef MULDIV_EARLY_OUT_EN
   logic               early_hit;
   logic [2*WIDTH-1:0] pp_shift;
   always_comb begin
      early_hit = ~is_div_q & ((q_q & ~({WIDTH{1'b1}} << cnt_q)) == '0);
      pp_shift  = {acc_q, q_q} >> cnt_q;
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         acc_q       <= '0;
         q_q         <= '0;
         b_q         <= '0;
         op_q        <= '0;
         neg_res_q   <= 1'b0;
         neg_rem_q   <= 1'b0;
         ovf_q       <= 1'b0;
         st_in_q     <= '0;
         out_valid_q <= 1'b0;
         fault_q     <= 1'b0;
         res_lo_q    <= '0;
         res_hi_q    <= '0;
         st_out_q    <= '0;
      end else if (bus.flush) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         fault_q     <= 1'b0;
         res_lo_q    <= '0;
         res_hi_q    <= '0;
         st_out_q    <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.in_valid) begin
                  op_q      <= bus.opc;
                  st_in_q   <= bus.status_in;
                  neg_res_q <= sgn0 ^ sgn1;
                  neg_rem_q <= sgn0;
                  ovf_q     <= is_idiv_in & (dvd_mag[2*WIDTH-1:WIDTH] >= mag1);
                  if (is_mul_in | is_imul_in) begin
                     acc_q <= '0;
                     q_q   <= mag1;
                     b_q   <= mag0;
                  end else begin
                     acc_q <= dvd_mag[2*WIDTH-1:WIDTH];
                     q_q   <= dvd_mag[WIDTH-1:0];
                     b_q   <= mag1;
                  end
                  if (early_fault | ~(is_mul_in | is_imul_in | is_div_in | is_idiv_in)) begin
                     state_q  <= ST_DONE;
                     cnt_q    <= '0;
                     res_lo_q <= '0;
                     res_hi_q <= '0;
                     st_out_q <= bus.status_in;
                     fault_q  <= early_fault;
                  end else begin
                     state_q <= ST_RUN;
                     cnt_q   <= CNT_FULL;
                  end
               end
            end
            ST_RUN: begin
`ifdef MULDIV_EARLY_OUT_EN
               if (early_hit) begin
                  acc_q   <= pp_shift[2*WIDTH-1:WIDTH];
                  q_q     <= pp_shift[WIDTH-1:0];
                  cnt_q   <= '0;
                  state_q <= ST_FIX;
               end else begin
                  acc_q <= acc_d;
                  q_q   <= q_d;
                  cnt_q <= cnt_q - 1'b1;
                  if (cnt_q == CW'(1)) state_q <= ST_FIX;
               end
`else
               acc_q <= acc_d;
               q_q   <= q_d;
               cnt_q <= cnt_q - 1'b1;
               if (cnt_q == CW'(1)) state_q <= ST_FIX;
`endif
            end
            ST_FIX: begin
               state_q <= ST_DONE;
               if (!is_div_q) begin
                  res_lo_q <= prod_fx[WIDTH-1:0];
                  res_hi_q <= prod_fx[2*WIDTH-1:WIDTH];
                  st_out_q <= mul_status(st_in_q, mul_ovf);
                  fault_q  <= 1'b0;
               end else if ((op_q == CMD_IDIV) && quo_ovf) begin
                  res_lo_q <= '0;
                  res_hi_q <= '0;
                  st_out_q <= st_in_q;
                  fault_q  <= 1'b1;
               end else begin
                  res_lo_q <= quo_fx;
                  res_hi_q <= rem_fx;
                  st_out_q <= st_in_q;
                  fault_q  <= 1'b0;
               end
            end
            ST_DONE: begin
               // out_valid rises one cycle after DONE is entered, then holds until taken
               if (!out_valid_q) begin
                  out_valid_q <= 1'b1;
               end else if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - directed scoreboard bench for muldiv_seq
module tb_muldiv_seq;
   import muldiv_seq_pkg::*;

   localparam int W = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   muldiv_seq_if #(.WIDTH(W)) bus ();
   muldiv_seq #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   typedef struct {
      logic [31:0] lo;
      logic [31:0] hi;
      logic [4:0]  st;
      logic        fault;
      int          lat;
      logic        is_mul;
      int          t_acc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   last_hs = 0;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      assert (act === exp) else begin
         failures++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, act, exp);
      end
   endtask

   function automatic exp_t model(input logic [5:0] opc, input logic [31:0] a0, input logic [31:0] a1,
                                  input logic [31:0] dh, input logic [4:0] st);
      exp_t        e;
      logic [63:0] up, ud, uq, ur;
      longint      sd, sq, sr;
      logic        cf;
      e = '{lo: '0, hi: '0, st: st, fault: 1'b0, lat: 1, is_mul: 1'b0, t_acc: 0};
      if (opc == CMD_MUL) begin
         up = {32'b0, a0} * {32'b0, a1};
         cf = (up[63:32] != 32'd0);
         e.lo = up[31:0]; e.hi = up[63:32];
         e.st = {cf, st[3:1], cf}; e.lat = 34; e.is_mul = 1'b1;
      end else if (opc == CMD_IMUL) begin
         sd = longint'(signed'(a0)) * longint'(signed'(a1));
         up = sd;
         cf = (up[63:32] != {32{up[31]}});
         e.lo = up[31:0]; e.hi = up[63:32];
         e.st = {cf, st[3:1], cf}; e.lat = 34; e.is_mul = 1'b1;
      end else if (opc == CMD_DIV) begin
         if (a1 == 32'd0 || dh >= a1) begin
            e.fault = 1'b1;
         end else begin
            ud = {dh, a0};
            uq = ud / {32'b0, a1};
            ur = ud % {32'b0, a1};
            e.lo = uq[31:0]; e.hi = ur[31:0]; e.lat = 34;
         end
      end else if (opc == CMD_IDIV) begin
         if (a1 == 32'd0) begin
            e.fault = 1'b1;
         end else begin
            sd = signed'({dh, a0});
            sq = sd / longint'(signed'(a1));
            sr = sd % longint'(signed'(a1));
            e.lat = 34;
            if (sq > 64'sd2147483647 || sq < -64'sd2147483648) begin
               e.fault = 1'b1;
            end else begin
               uq = sq; ur = sr;
               e.lo = uq[31:0]; e.hi = ur[31:0];
            end
         end
      end
      return e;
   endfunction

   task automatic issue(input logic [5:0] opc, input logic [31:0] a0, input logic [31:0] a1,
                        input logic [31:0] dh, input logic [4:0] st, output int t_acc);
      int n = 0;
      @(negedge clk);
      while (!bus.in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("in_ready_wait", 64'(bus.in_ready), 64'd1);
      bus.opc = opc; bus.opnd0_r = a0; bus.opnd1_r = a1; bus.divd_hi_r = dh; bus.status_in = st;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      t_acc = cyc;
      bus.in_valid = 1'b0;
   endtask

   task automatic send(input logic [5:0] opc, input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] dh, input logic [4:0] st, output int t_acc);
      exp_t e;
      issue(opc, a0, a1, dh, st, t_acc);
      e = model(opc, a0, a1, dh, st);
      e.t_acc = t_acc;
      sb.push_back(e);
   endtask

   task automatic collect(input string tag, input int hold);
      exp_t e;
      int   n = 0;
      int   lat;
      chk({tag, "_sb_nonempty"}, 64'(sb.size() != 0), 64'd1);
      if (sb.size() == 0) return;
      e = sb.pop_front();
      do begin
         @(negedge clk);
         n++;
      end while (!bus.out_valid && n < 200);
      chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd1);
      lat = cyc - e.t_acc;
`ifdef MULDIV_EARLY_OUT_EN
      if (e.is_mul) chk({tag, "_lat_range"}, 64'(lat >= 3 && lat <= 34), 64'd1);
      else chk({tag, "_lat"}, 64'(lat), 64'(e.lat));
`else
      chk({tag, "_lat"}, 64'(lat), 64'(e.lat));
`endif
      chk({tag, "_lo"}, 64'(bus.result_lo), 64'(e.lo));
      chk({tag, "_hi"}, 64'(bus.result_hi), 64'(e.hi));
      chk({tag, "_status"}, 64'(bus.status_out), 64'(e.st));
      chk({tag, "_fault"}, 64'(bus.div_fault), 64'(e.fault));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk({tag, "_hold_valid"}, 64'(bus.out_valid), 64'd1);
         chk({tag, "_hold_lo"}, 64'(bus.result_lo), 64'(e.lo));
         chk({tag, "_hold_hi"}, 64'(bus.result_hi), 64'(e.hi));
         chk({tag, "_hold_ready"}, 64'(bus.in_ready), 64'd0);
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      last_hs = cyc;
      bus.out_ready = 1'b0;
      chk({tag, "_valid_drop"}, 64'(bus.out_valid), 64'd0);
   endtask

   task automatic check_idle_zero(input string tag);
      chk({tag, "_state"}, 64'(dut.state_q), 64'(MULDIV_ST_IDLE));
      chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
      chk({tag, "_lo"}, 64'(bus.result_lo), 64'd0);
      chk({tag, "_hi"}, 64'(bus.result_hi), 64'd0);
      chk({tag, "_status"}, 64'(bus.status_out), 64'd0);
      chk({tag, "_fault"}, 64'(bus.div_fault), 64'd0);
   endtask

   task automatic watch_no_valid(input string tag, input int ncyc);
      logic seen = 1'b0;
      for (int i = 0; i < ncyc; i++) begin
         @(negedge clk);
         seen |= bus.out_valid;
      end
      chk({tag, "_no_result"}, 64'(seen), 64'd0);
   endtask

   initial begin
      int t;
      bus.in_valid = 1'b0; bus.opc = '0; bus.opnd0_r = '0; bus.opnd1_r = '0; bus.divd_hi_r = '0;
      bus.status_in = '0; bus.flush = 1'b0; bus.out_ready = 1'b0;

      repeat (2) @(negedge clk);
      check_idle_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);
      chk("reset_in_ready", 64'(bus.in_ready), 64'd1);

      send(CMD_MUL, 32'hFFFFFFFF, 32'd2, 32'd0, 5'b01010, t);
      collect("mul_max", 0);
      send(CMD_IDIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 5'b00100, t);
      collect("idiv_m7_2", 0);
      send(CMD_DIV, 32'd1234, 32'd0, 32'd0, 5'b10110, t);
      collect("div_zero", 0);
      send(CMD_DIV, 32'd0, 32'd5, 32'd5, 5'b01001, t);
      collect("div_hi_ovf", 0);
      send(CMD_IDIV, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'b00011, t);
      collect("idiv_min_m1", 0);
      send(CMD_IMUL, 32'hFFFFFFFD, 32'd5, 32'd0, 5'b01110, t);
      collect("imul_m3_5", 0);
      send(CMD_IMUL, 32'h80000000, 32'h80000000, 32'd0, 5'b00000, t);
      collect("imul_min_sq", 0);
      send(CMD_DIV, 32'd0, 32'd3, 32'd1, 5'b11111, t);
      collect("div_2p32_3", 0);
      send(CMD_IDIV, 32'd100, 32'hFFFFFFF9, 32'd0, 5'b00010, t);
      collect("idiv_100_m7", 0);
      send(CMD_IDIV, 32'h80000000, 32'h80000000, 32'hFFFFFFFF, 5'b00000, t);
      collect("idiv_min_min", 0);
      send(CMD_IDIV, 32'd0, 32'd2, 32'h00000010, 5'b01000, t);
      collect("idiv_big", 0);
      send(6'h3F, 32'd7, 32'd9, 32'd0, 5'b10101, t);
      collect("bad_opc", 0);

      send(CMD_MUL, 32'h00012345, 32'h00006789, 32'd0, 5'b00001, t);
      collect("hold", 10);
      send(CMD_IMUL, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'd0, 5'b00000, t);
      chk("b2b_accept", 64'(t), 64'(last_hs + 1));
      collect("imul_b2b", 0);

      issue(CMD_MUL, 32'd7, 32'd9, 32'd0, 5'b00000, t);
      do @(negedge clk); while (cyc < t + 9);
      bus.flush = 1'b1;
      @(posedge clk);
      #1;
      bus.flush = 1'b0;
      check_idle_zero("flush");
      chk("flush_in_ready", 64'(bus.in_ready), 64'd1);
      watch_no_valid("flush", 40);
      send(CMD_MUL, 32'd3, 32'd5, 32'd0, 5'b00000, t);
      collect("mul_after_flush", 0);

      issue(CMD_MUL, 32'd11, 32'd13, 32'd0, 5'b00000, t);
      do @(negedge clk); while (cyc < t + 9);
      rst_n = 1'b0;
      #1;
      check_idle_zero("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
      watch_no_valid("midrst", 40);
      send(CMD_MUL, 32'd3, 32'd5, 32'd0, 5'b00000, t);
      collect("mul_after_rst", 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
